// File: rtl/tg_pkg.sv
// Shared FSM states and LFSR step for the cache traffic generator.
package tg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ISSUE,
    S_WAIT_RD,
    S_DONE
  } tg_state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/tg_shadow_mem.sv
// Shadow copy of written words: per-byte write, valid bit per word.
module tg_shadow_mem
  import tg_pkg::*;
#(
  parameter int RANGE_W = 8,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [RANGE_W-1:0]  addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
);

  localparam int DEPTH = 1 << RANGE_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  // Data array is never reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata  = mem_q[addr];
  assign rvalid = valid_q[addr];

endmodule

// File: rtl/cache_traffic_gen.sv
// Pseudo-random read/write traffic generator with shadow-memory checking.
// Optional random write byte enables: define TG_RAND_BE_EN.
module cache_traffic_gen
  import tg_pkg::*;
#(
  parameter int          ADDR_W    = 25,
  parameter int          DATA_W    = 32,
  parameter int          RANGE_W   = 8,
  parameter int          NUM_OPS   = 100,
  parameter int          WR_THRESH = 128,
  parameter logic [31:0] SEED      = 32'hACE1_2468,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_p_addr,
  output logic [DATA_W/8-1:0] o_p_byte_en,
  output logic [DATA_W-1:0]   o_p_writedata,
  output logic                o_p_read,
  output logic                o_p_write,
  input  logic [DATA_W-1:0]   i_p_readdata,
  input  logic                i_p_readdata_valid,
  input  logic                i_p_waitrequest,
  output logic                o_err,
  output logic [ADDR_W-1:0]   o_err_addr,
  output logic [31:0]         o_cnt_r,
  output logic [31:0]         o_cnt_w,
  output logic [31:0]         o_cnt_err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = '1;

  tg_state_e         state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [31:0]       cnt_r_q, cnt_r_d;
  logic [31:0]       cnt_w_q, cnt_w_d;
  logic [31:0]       cnt_err_q, cnt_err_d;
  logic [31:0]       ops_q, ops_d;
  logic [31:0]       tmo_q, tmo_d;

  logic [31:0]       lfsr_n;
  logic [31:0]       mix;
  logic [DATA_W-1:0] data_n;
  logic [ADDR_W-1:0] addr_n;
  logic [BE_W-1:0]   be_n;
  logic              wr_n;
  logic              accept;
  logic              op_end;
  logic              err_ev;
  logic              sh_we;
  logic [DATA_W-1:0] sh_rdata;
  logic              sh_rvalid;

  tg_shadow_mem #(
    .RANGE_W (RANGE_W),
    .DATA_W  (DATA_W)
  ) u_shadow (
    .clk    (clk),
    .clr    (~rst),
    .we     (sh_we),
    .be     (be_q),
    .addr   (addr_q[RANGE_W-1:0]),
    .wdata  (wdata_q),
    .rdata  (sh_rdata),
    .rvalid (sh_rvalid)
  );

  always_comb begin
    lfsr_n = lfsr_next(lfsr_q);
    mix    = lfsr_n ^ {lfsr_n[15:0], lfsr_n[31:16]};
    data_n = DATA_W'({((DATA_W + 31) / 32){mix}});
    addr_n = '0;
    addr_n[RANGE_W-1:0] = lfsr_n[RANGE_W-1:0];
    wr_n   = {24'd0, lfsr_n[31:24]} < 32'(WR_THRESH);
`ifdef TG_RAND_BE_EN
    be_n = BE_ALL;
    if (wr_n && (lfsr_n[BE_W+15:16] != '0)) begin
      be_n = lfsr_n[BE_W+15:16];
    end
`else
    be_n = BE_ALL;
`endif
  end

  assign accept = (read_q | write_q) & ~i_p_waitrequest;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    read_d     = read_q;
    write_d    = write_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    cnt_r_d    = cnt_r_q;
    cnt_w_d    = cnt_w_q;
    cnt_err_d  = cnt_err_q;
    ops_d      = ops_q;
    tmo_d      = tmo_q;
    op_end     = 1'b0;
    err_ev     = 1'b0;
    sh_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        err_ev = i_p_readdata_valid;
        if (i_start) begin
          state_d   = S_GEN;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          cnt_r_d   = '0;
          cnt_w_d   = '0;
          cnt_err_d = '0;
          ops_d     = '0;
        end
      end
      S_GEN: begin
        err_ev  = i_p_readdata_valid;
        lfsr_d  = lfsr_n;
        addr_d  = addr_n;
        wdata_d = data_n;
        be_d    = be_n;
        read_d  = ~wr_n;
        write_d = wr_n;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        err_ev = i_p_readdata_valid;
        if (accept) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ops_d   = ops_q + 32'd1;
          if (write_q) begin
            sh_we   = 1'b1;
            cnt_w_d = cnt_w_q + 32'd1;
            op_end  = 1'b1;
          end else begin
            cnt_r_d = cnt_r_q + 32'd1;
            tmo_d   = '0;
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        if (i_p_readdata_valid) begin
          err_ev = sh_rvalid && (i_p_readdata != sh_rdata);
          op_end = 1'b1;
        end else if (tmo_q == 32'(TIMEOUT - 1)) begin
          err_ev = 1'b1;
          op_end = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_DONE: begin
        err_ev  = i_p_readdata_valid;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (op_end) begin
      if (ops_d >= 32'(NUM_OPS)) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_GEN;
      end
    end

    if (err_ev) begin
      cnt_err_d = cnt_err_d + 32'd1;
      err_d     = 1'b1;
      if (!err_q) begin
        err_addr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= BE_ALL;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_r_q    <= '0;
      cnt_w_q    <= '0;
      cnt_err_q  <= '0;
      ops_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      read_q     <= read_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cnt_r_q    <= cnt_r_d;
      cnt_w_q    <= cnt_w_d;
      cnt_err_q  <= cnt_err_d;
      ops_q      <= ops_d;
      tmo_q      <= tmo_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_p_addr      = addr_q;
  assign o_p_byte_en   = be_q;
  assign o_p_writedata = wdata_q;
  assign o_p_read      = read_q;
  assign o_p_write     = write_q;
  assign o_err         = err_q;
  assign o_err_addr    = err_addr_q;
  assign o_cnt_r       = cnt_r_q;
  assign o_cnt_w       = cnt_w_q;
  assign o_cnt_err     = cnt_err_q;

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
- Parametrised, synthesizable successor to the cache bench stimulus loop.
- Drives the processor-side port of the cache (i_p_* / o_p_* convention) with pseudo-random reads and writes.
- Honours waitrequest and readdata_valid. Keeps a shadow memory of everything written and checks every read of a written word.
- Used in simulation and on-board soak tests.

Parameters:
- ADDR_W, 25: processor address width.
- DATA_W, 32: data width; multiple of 8. BE_W = DATA_W/8.
- RANGE_W, 8: address window bits. Addresses are 0 .. 2^RANGE_W-1; shadow depth is 2^RANGE_W.
- NUM_OPS, 100: accepted operations per run, at least 1.
- WR_THRESH, 128: op is a write when lfsr[31:24] < WR_THRESH. 0 gives all reads; 256 gives all writes.
- SEED, 32'hACE1_2468: LFSR reset value; must be nonzero.
- TIMEOUT, 1024: maximum cycles from read acceptance to readdata_valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle pulse; begins a run when idle. Ignored when busy.
- o_busy  out  1  run in progress.
- o_done  out  1  high from end of run until next i_start.
- o_p_addr  out  ADDR_W  request address.
- o_p_byte_en  out  BE_W  byte enables.
- o_p_writedata  out  DATA_W  write data.
- o_p_read  out  1  read request.
- o_p_write  out  1  write request.
- i_p_readdata  in  DATA_W  read data.
- i_p_readdata_valid  in  1  read data strobe.
- i_p_waitrequest  in  1  stall; request not accepted while high.
- o_err  out  1  sticky: mismatch or timeout seen.
- o_err_addr  out  ADDR_W  address of first error.
- o_cnt_r  out  32  accepted reads.
- o_cnt_w  out  32  accepted writes.
- o_cnt_err  out  32  total errors.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State is IDLE; LFSR = SEED.
  - All outputs are 0, except o_p_byte_en = all ones.
  - Shadow valid bits are cleared. Shadow data is not reset.
- LFSR: 32-bit Galois, mask 32'h8020_0003, advanced once per GEN.
  - addr = zero-extended lfsr[RANGE_W-1:0].
  - data = lfsr XOR {lfsr[15:0], lfsr[31:16]}, replicated to DATA_W.
- FSM states: IDLE, GEN, ISSUE, WAIT_RD, DONE.
- IDLE: on i_start, go to GEN. Clear counters, o_err and o_done; set o_busy.
- GEN (1 cycle):
  - Step the LFSR.
  - Register addr, data and op into the request registers.
  - Go to ISSUE.
- ISSUE:
  - Assert o_p_read or o_p_write. Addr, data and byte_en are held stable while i_p_waitrequest=1.
  - Acceptance occurs when the request is high and i_p_waitrequest=0 in the same cycle.
  - Write accepted:
    - Merge the bytes into shadow[addr] and set valid[addr].
    - Increment o_cnt_w.
    - Go to GEN, or to DONE if the op count reaches NUM_OPS.
  - Read accepted: increment o_cnt_r, start the timeout counter, go to WAIT_RD.
  - The request is deasserted in the cycle after acceptance.
- WAIT_RD:
  - On i_p_readdata_valid: if valid[addr] and the data differs from shadow[addr], record an error.
  - If valid[addr]=0, the returned data is not checked.
  - Then go to GEN or DONE.
  - If the timeout counter reaches TIMEOUT first, record an error and continue to GEN or DONE.
  - readdata_valid in any state other than WAIT_RD is ignored and counts as an error.
- Recording an error:
  - Increment o_cnt_err.
  - Set o_err.
  - Latch o_err_addr only when o_err was 0 before this error.
- DONE: o_busy=0, o_done=1. Go to IDLE on the next cycle; o_done stays high until the next i_start.
- Only one operation is outstanding at a time. Counters wrap at 2^32.
- Reset mid-run aborts immediately: requests drop in the same cycle reset is sampled.

Optional Feature:
- Macro: TG_RAND_BE_EN.
- Defined:
  - Writes use byte_en = lfsr[BE_W+15:16]; all-zero is forced to all ones.
  - The shadow merges only the enabled bytes.
  - Reads always use all ones.
- Undefined: byte_en is all ones; shadow writes whole words.

Decomposition:
- Package tg_pkg holds:
  - the FSM state enum;
  - the LFSR mask constant;
  - function lfsr_next.
- Sub-module tg_shadow_mem:
  - 2^RANGE_W x DATA_W storage, per-byte write enable;
  - valid bit array with synchronous clear;
  - combinational read.

Test Plan:
- Zero-wait memory model, NUM_OPS=100, WR_THRESH=128 -> o_done within 400 cycles; o_cnt_r + o_cnt_w = 100; o_err=0.
- i_p_waitrequest high for 5 cycles on every request -> request fields stable throughout; counters exact; no duplicated ops.
- Memory model corrupts bit 0 of read data at addr 8'h2A after a write there -> o_err=1, o_err_addr=25'h2A, o_cnt_err=1.
- Memory model never returns readdata_valid on first read, TIMEOUT=16 -> error after 16 cycles; run still completes.
- WR_THRESH=0, fresh reset -> only reads, o_cnt_w=0, o_err=0 (shadow never valid).
- rst=0 during ISSUE of op 50 -> next cycle o_p_read=0, o_p_write=0, o_busy=0; new i_start replays the identical sequence from SEED.
